sme2_za_ldst: RTL and testbench

Streaming load/store sequencer for the SME2 ZA array. It accepts row-block commands, moves 512-bit rows from a memory-side load stream into ZA through the core's ZA write port, and reads ZA rows out to a memory-side store stream. It sits directly upstream of `sme2_core`, driving `za_addr`, `za_wdata` and `za_write_en`, and consumes `za_rdata`.

---
 rtl/sme2_pkg.sv | 21 ++
 rtl/sme2_ldst_perf.sv | 25 ++
 rtl/sme2_za_ldst.sv | 152 +++++++++++++++
 tb/tb_sme2_za_ldst.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme2_pkg.sv
// Shared SME2 constants: ZA geometry, load/store sequencer state codes, direction encoding.
package sme2_pkg;

  localparam int unsigned ZA_ROW_W  = 512;
  localparam int unsigned ZA_ADDR_W = 8;

  typedef logic [1:0] ldst_state_t;

  localparam ldst_state_t ST_IDLE  = 2'd0;
  localparam ldst_state_t ST_LOAD  = 2'd1;
  localparam ldst_state_t ST_STORE = 2'd2;
  localparam ldst_state_t ST_DONE  = 2'd3;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sme2_ldst_perf.sv
// Saturating row / stall counters for the ZA load/store sequencer.
module sme2_ldst_perf
  import sme2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        beat,
  output logic [31:0] perf_rows,
  output logic [31:0] perf_stall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rows  <= '0;
      perf_stall <= '0;
    end else begin
      if (beat)
        perf_rows <= sat_inc32(perf_rows);
      if (active && !beat)
        perf_stall <= sat_inc32(perf_stall);
    end
  end

endmodule

// File: rtl/sme2_za_ldst.sv
// ZA row-block load/store sequencer feeding sme2_core's ZA port.
// Optional perf counters built when SME2_ZA_LDST_PERF_EN is defined.
module sme2_za_ldst
  import sme2_pkg::*;
#(
  parameter int unsigned DATA_W = ZA_ROW_W,
  parameter int unsigned ADDR_W = ZA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_rows,
  input  logic              za_enabled,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [DATA_W-1:0] st_data,
  output logic [ADDR_W-1:0] za_addr,
  output logic [DATA_W-1:0] za_wdata,
  output logic              za_write_en,
  input  logic [DATA_W-1:0] za_rdata,
  output logic              done,
  output logic              err
`ifdef SME2_ZA_LDST_PERF_EN
  ,
  output logic [31:0]       perf_rows,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  ldst_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   rows;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   issue;
  logic              err_q;

  logic is_load, is_store;
  logic ld_beat, st_accept, st_capture;
  logic last_load, last_store;

  always_comb begin
    is_load    = (state == ST_LOAD);
    is_store   = (state == ST_STORE);
    ld_beat    = is_load && za_enabled && ld_valid;
    st_accept  = is_store && st_valid && st_ready;
    st_capture = is_store && za_enabled && (issue < rows) && (!st_valid || st_ready);
    last_load  = ld_beat && (cnt == rows - ONE);
    // Once every row has been issued, the final accept drains the skid register.
    last_store = st_accept && (issue == rows);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      base     <= '0;
      rows     <= '0;
      cnt      <= '0;
      issue    <= '0;
      st_valid <= 1'b0;
      st_data  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            base  <= cmd_base;
            rows  <= cmd_rows;
            cnt   <= '0;
            issue <= '0;
            if (!za_enabled) begin
              state <= ST_DONE;
              err_q <= 1'b1;
            end else if (cmd_rows == '0) begin
              state <= ST_DONE;
              err_q <= 1'b0;
            end else begin
              state <= (cmd_store == DIR_STORE) ? ST_STORE : ST_LOAD;
              err_q <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (!za_enabled) begin
            state <= ST_DONE;
            err_q <= 1'b1;
          end else if (ld_beat) begin
            cnt <= cnt + ONE;
            if (last_load)
              state <= ST_DONE;
          end
        end
        ST_STORE: begin
          if (!za_enabled) begin
            state    <= ST_DONE;
            err_q    <= 1'b1;
            st_valid <= 1'b0;
          end else begin
            if (st_capture) begin
              st_data  <= za_rdata;
              st_valid <= 1'b1;
              issue    <= issue + ONE;
            end else if (st_accept) begin
              st_valid <= 1'b0;
            end
            if (last_store)
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          err_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready   = (state == ST_IDLE);
    ld_ready    = is_load && za_enabled;
    za_write_en = ld_beat;
    za_wdata    = is_load ? ld_data : '0;
    if (is_load)
      za_addr = base + cnt[ADDR_W-1:0];
    else if (is_store)
      za_addr = base + issue[ADDR_W-1:0];
    else
      za_addr = '0;
    done = (state == ST_DONE);
    err  = done && err_q;
  end

`ifdef SME2_ZA_LDST_PERF_EN
  sme2_ldst_perf u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (is_load || is_store),
    .beat      (ld_beat || st_accept),
    .perf_rows (perf_rows),
    .perf_stall(perf_stall)
  );
`endif

endmodule

// File: tb/tb_sme2_za_ldst.sv
// Directed self-checking bench for sme2_za_ldst with a behavioural ZA row store.
module tb_sme2_za_ldst;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_store;
  logic [7:0]   cmd_base;
  logic [8:0]   cmd_rows;
  logic         za_enabled;
  logic         ld_valid;
  logic         ld_ready;
  logic [511:0] ld_data;
  logic         st_valid;
  logic         st_ready;
  logic [511:0] st_data;
  logic [7:0]   za_addr;
  logic [511:0] za_wdata;
  logic         za_write_en;
  logic [511:0] za_rdata;
  logic         done;
  logic         err;
`ifdef SME2_ZA_LDST_PERF_EN
  logic [31:0]  perf_rows;
  logic [31:0]  perf_stall;
`endif

  sme2_za_ldst #(.DATA_W(512), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_store  (cmd_store),
    .cmd_base   (cmd_base),
    .cmd_rows   (cmd_rows),
    .za_enabled (za_enabled),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_data    (st_data),
    .za_addr    (za_addr),
    .za_wdata   (za_wdata),
    .za_write_en(za_write_en),
    .za_rdata   (za_rdata),
    .done       (done),
    .err        (err)
`ifdef SME2_ZA_LDST_PERF_EN
    ,
    .perf_rows  (perf_rows),
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [511:0] mem [256];
  logic         pl_en;
  logic [7:0]   pl_addr;
  logic [511:0] pl_data;
  int           wr_count;

  assign za_rdata = mem[za_addr];

  initial wr_count = 0;
  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (za_write_en) begin
      mem[za_addr] <= za_wdata;
      wr_count <= wr_count + 1;
    end
  end

  int checks;
  int failures;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [511:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    cyc();
    pl_en = 1'b0;
  endtask

  logic [511:0] exp_st [4];
  logic [511:0] held;
  logic         held_valid;
  logic         got_done;
  int           k;
  int           wr_base;
  int           done_seen;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0; cmd_rows = '0;
    za_enabled = 1'b1; ld_valid = 1'b0; ld_data = '0; st_ready = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    cyc(); cyc();
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_st_valid", st_valid, 0);
    check("rst_st_data", st_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_za_we", za_write_en, 0);
    check("rst_za_addr", za_addr, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Load 4 rows at 0x10.
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 8'h10; cmd_rows = 9'd4;
    ld_valid = 1'b1; ld_data = 512'hA0;
    #1 check("ld_accept_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_data = 512'hA0 + 512'(i);
      #1;
      check("ld_we", za_write_en, 1);
      check("ld_addr", za_addr, 8'h10 + 8'(i));
      check("ld_wdata", za_wdata, 512'hA0 + 512'(i));
      check("ld_ready", ld_ready, 1);
      check("ld_no_done", done, 0);
      cyc();
    end
    ld_valid = 1'b0;
    #1;
    check("ld_done", done, 1);
    check("ld_err", err, 0);
    check("ld_done_we", za_write_en, 0);
    check("ld_done_cmd_ready", cmd_ready, 0);
    check("ld_mem13", mem[8'h13], 512'hA3);
    cyc();
    #1 check("ld_idle_ready", cmd_ready, 1);

    // Store 4 rows with wrap from 0xFE.
    exp_st[0] = {64{8'hFE}}; exp_st[1] = {64{8'hFF}};
    exp_st[2] = {64{8'h00}} | 512'h5A; exp_st[3] = {64{8'h01}};
    preload(8'hFE, exp_st[0]); preload(8'hFF, exp_st[1]);
    preload(8'h00, exp_st[2]); preload(8'h01, exp_st[3]);
    st_ready = 1'b1;
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_base = 8'hFE; cmd_rows = 9'd4;
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("st_first_invalid", st_valid, 0);
    check("st_first_addr", za_addr, 8'hFE);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("st_valid", st_valid, 1);
      check("st_data", st_data, exp_st[i]);
      check("st_no_done", done, 0);
      cyc();
    end
    #1;
    check("st_done", done, 1);
    check("st_err", err, 0);
    check("st_done_valid", st_valid, 0);
    cyc();

    // Store 3 rows under back-pressure.
    exp_st[0] = {16{32'h1111_2020}}; exp_st[1] = {16{32'h2222_2121}}; exp_st[2] = {16{32'h3333_2222}};
    preload(8'h20, exp_st[0]); preload(8'h21, exp_st[1]); preload(8'h22, exp_st[2]);
    st_ready = 1'b0;
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_base = 8'h20; cmd_rows = 9'd3;
    cyc();
    cmd_valid = 1'b0;
    k = 0; held_valid = 1'b0; got_done = 1'b0; held = '0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      st_ready = (c % 2 == 0);
      #1;
      if (done) begin
        got_done = 1'b1;
        check("bp_err", err, 0);
      end else begin
        if (held_valid && st_valid)
          check("bp_hold", st_data, held);
        if (st_valid && st_ready) begin
          if (k < 3) check("bp_data", st_data, exp_st[k]);
          else check("bp_extra_beat", 512'(k), 512'd2);
          k++;
          held_valid = 1'b0;
        end else if (st_valid) begin
          held = st_data;
          held_valid = 1'b1;
        end else begin
          held_valid = 1'b0;
        end
      end
      cyc();
    end
    check("bp_count", 512'(k), 512'd3);
    check("bp_got_done", got_done, 1);
    st_ready = 1'b1;

    // ZA disabled at accept.
    wr_base = wr_count;
    za_enabled = 1'b0;
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 8'h30; cmd_rows = 9'd4; ld_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("dis_done", done, 1);
    check("dis_err", err, 1);
    check("dis_we", za_write_en, 0);
    check("dis_st_valid", st_valid, 0);
    cyc();
    ld_valid = 1'b0;
    za_enabled = 1'b1;
    #1;
    check("dis_idle", cmd_ready, 1);
    check("dis_writes", 512'(wr_count - wr_base), 512'd0);

    // Abort after the 2nd of 8 load beats.
    preload(8'h42, {16{32'hDEAD_BEEF}});
    wr_base = wr_count;
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 8'h40; cmd_rows = 9'd8;
    ld_valid = 1'b1; ld_data = 512'hB0;
    cyc();
    cmd_valid = 1'b0;
    #1 check("ab_we1", za_write_en, 1);
    cyc();
    ld_data = 512'hB1;
    #1 check("ab_we2", za_write_en, 1);
    cyc();
    ld_data = 512'hB2;
    za_enabled = 1'b0;
    #1;
    check("ab_we_fall", za_write_en, 0);
    check("ab_no_done_yet", done, 0);
    cyc();
    #1;
    check("ab_done", done, 1);
    check("ab_err", err, 1);
    cyc();
    ld_valid = 1'b0;
    za_enabled = 1'b1;
    #1;
    check("ab_idle", cmd_ready, 1);
    check("ab_writes", 512'(wr_count - wr_base), 512'd2);
    check("ab_mem41", mem[8'h41], 512'hB1);
    check("ab_mem42", mem[8'h42], {16{32'hDEAD_BEEF}});

    // Zero-row command.
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 8'h50; cmd_rows = 9'd0;
    cyc();
    cmd_valid = 1'b0;
    #1;
    check("z_done", done, 1);
    check("z_err", err, 0);
    cyc();

    // Reset in the middle of a 16-row load.
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 8'h60; cmd_rows = 9'd16;
    ld_valid = 1'b1; ld_data = 512'hC0;
    cyc();
    cmd_valid = 1'b0;
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("mr_cmd_ready", cmd_ready, 1);
    check("mr_ld_ready", ld_ready, 0);
    check("mr_we", za_write_en, 0);
    check("mr_addr", za_addr, 0);
    check("mr_done", done, 0);
    check("mr_err", err, 0);
    check("mr_st_valid", st_valid, 0);
    check("mr_st_data", st_data, 0);
    cyc();
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done) done_seen++;
      cyc();
    end
    ld_valid = 1'b0;
    check("mr_no_done", 512'(done_seen), 512'd0);
    check("mr_idle", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
